// File: rtl/des_round_controller.sv
// des_round_controller
//   Sequences one DES block through the 16 rounds of a shared round-function
//   datapath. Owns the C/D key-schedule registers and emits the L/R load and
//   round-update strobes, round number and output handshake.
//
// Ports
//   Clk        in   clock, rising edge
//   Rst        in   synchronous active-high reset
//   Start      in   request one block (honoured only in IDLE)
//   Decrypt    in   direction latched with an accepted Start (1 = decrypt)
//   Key_In     in   56-bit post-PC-1 key, [56:29] = C, [28:1] = D
//   Stall      in   datapath not ready, holds the current round (STALL_EN=1)
//   Out_Ready  in   consumer takes the finished block
//   Load_Data  out  comb, datapath loads IP(block) on this edge
//   Round_En   out  comb, datapath updates L/R on this edge
//   Round_Num  out  current round 0..15
//   Last_Round out  round 15 active, datapath suppresses the swap
//   Key_C      out  C half of the current round's subkey
//   Key_D      out  D half of the current round's subkey
//   Busy       out  controller not idle
//   Out_Valid  out  registered, finished block present on datapath output
module des_round_controller #(
    parameter int unsigned STALL_EN   = 1,
    parameter int unsigned NUM_ROUNDS = 16
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         Start,
    input  logic         Decrypt,
    input  logic [56:1]  Key_In,
    input  logic         Stall,
    input  logic         Out_Ready,
    output logic         Load_Data,
    output logic         Round_En,
    output logic [3:0]   Round_Num,
    output logic         Last_Round,
    output logic [27:0]  Key_C,
    output logic [27:0]  Key_D,
    output logic         Busy,
    output logic         Out_Valid
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ROUND,
        S_OUT
    } state_t;

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS - 1);

    state_t      state_q, state_d;
    logic [3:0]  round_q, round_d;
    logic [27:0] c_q, c_d;
    logic [27:0] d_q, d_d;
    logic        dec_q, dec_d;
    logic        valid_q, valid_d;
    logic        stall_gate;

    // DES shift table: s[i] is 1 for i in {1,2,9,16}, else 2.
    function automatic logic shift_is_one(input logic [4:0] idx);
        return (idx == 5'd1) || (idx == 5'd2) || (idx == 5'd9) || (idx == 5'd16);
    endfunction

    function automatic logic [27:0] rotl28(input logic [27:0] x, input logic one);
        return one ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic one);
        return one ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
    endfunction

    assign stall_gate = Stall & (STALL_EN != 0);

    always_comb begin
        state_d   = state_q;
        round_d   = round_q;
        c_d       = c_q;
        d_d       = d_q;
        dec_d     = dec_q;
        valid_d   = valid_q;
        Load_Data = 1'b0;
        Round_En  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    Load_Data = 1'b1;
                    state_d   = S_ROUND;
                    round_d   = '0;
                    dec_d     = Decrypt;
                    // Decrypt starts at K16, whose total rotation of 28 is
                    // the unrotated PC-1 key.
                    if (Decrypt) begin
                        c_d = Key_In[56:29];
                        d_d = Key_In[28:1];
                    end else begin
                        c_d = rotl28(Key_In[56:29], 1'b1);
                        d_d = rotl28(Key_In[28:1], 1'b1);
                    end
                end
            end
            S_ROUND: begin
                if (!stall_gate) begin
                    Round_En = 1'b1;
                    if (round_q == LAST_ROUND) begin
                        state_d = S_OUT;
                        valid_d = 1'b1;
                    end else begin
                        round_d = round_q + 4'd1;
                        // Encrypt moves forward to K(r+2); decrypt undoes the
                        // shift that produced K(16-r).
                        if (dec_q) begin
                            c_d = rotr28(c_q, shift_is_one(5'd16 - {1'b0, round_q}));
                            d_d = rotr28(d_q, shift_is_one(5'd16 - {1'b0, round_q}));
                        end else begin
                            c_d = rotl28(c_q, shift_is_one({1'b0, round_q} + 5'd2));
                            d_d = rotl28(d_q, shift_is_one({1'b0, round_q} + 5'd2));
                        end
                    end
                end
            end
            S_OUT: begin
                if (Out_Ready) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Reset wins: no datapath strobes on an edge that resets the block.
        if (Rst) begin
            Load_Data = 1'b0;
            Round_En  = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= S_IDLE;
            round_q <= '0;
            c_q     <= '0;
            d_q     <= '0;
            dec_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            c_q     <= c_d;
            d_q     <= d_d;
            dec_q   <= dec_d;
            valid_q <= valid_d;
        end
    end

    assign Round_Num  = round_q;
    assign Last_Round = (state_q == S_ROUND) && (round_q == LAST_ROUND);
    assign Key_C      = c_q;
    assign Key_D      = d_q;
    assign Busy       = (state_q != S_IDLE);
    assign Out_Valid  = valid_q;

endmodule

// File: tb/tb_des_round_controller.sv
// Bench for des_round_controller: two instances (STALL_EN=1 and STALL_EN=0)
// share stimulus; a block-level model predicts every output each cycle, and
// directed literals pin the key walk and latencies.
module tb_des_round_controller;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        Start = 1'b0;
    logic        Decrypt = 1'b0;
    logic        Stall = 1'b0;
    logic        Out_Ready = 1'b1;
    logic [56:1] Key_In = '0;

    logic [1:0]       ld, re, lr, busy, ov;
    logic [1:0][3:0]  rn;
    logic [1:0][27:0] kc, kd;

    always #5 Clk = ~Clk;

    des_round_controller #(.STALL_EN(1), .NUM_ROUNDS(16)) u_dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .Decrypt(Decrypt), .Key_In(Key_In),
        .Stall(Stall), .Out_Ready(Out_Ready), .Load_Data(ld[0]), .Round_En(re[0]),
        .Round_Num(rn[0]), .Last_Round(lr[0]), .Key_C(kc[0]), .Key_D(kd[0]),
        .Busy(busy[0]), .Out_Valid(ov[0])
    );

    des_round_controller #(.STALL_EN(0), .NUM_ROUNDS(16)) u_dut_ns (
        .Clk(Clk), .Rst(Rst), .Start(Start), .Decrypt(Decrypt), .Key_In(Key_In),
        .Stall(Stall), .Out_Ready(Out_Ready), .Load_Data(ld[1]), .Round_En(re[1]),
        .Round_Num(rn[1]), .Last_Round(lr[1]), .Key_C(kc[1]), .Key_D(kd[1]),
        .Busy(busy[1]), .Out_Valid(ov[1])
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    // ---------------- model ----------------
    int          sh [17] = '{0, 1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    bit          se [2]  = '{1'b1, 1'b0};
    int          m_phase [2] = '{0, 0};   // 0 idle, 1 rounds, 2 output
    int          m_round [2] = '{0, 0};
    bit          m_dec   [2] = '{0, 0};
    bit          m_keyset[2] = '{0, 0};
    logic [27:0] m_c0    [2] = '{28'h0, 28'h0};
    logic [27:0] m_d0    [2] = '{28'h0, 28'h0};

    function automatic logic [27:0] rotl(input logic [27:0] x, input int n);
        logic [27:0] r;
        if (n == 0) return x;
        r = (x << n) | (x >> (28 - n));
        return r;
    endfunction

    // Subkey K_i is the PC-1 key rotated left by the sum of s[1..i].
    function automatic logic [27:0] exp_key(input logic [27:0] base, input bit dec,
                                            input int r, input bit set);
        int idx;
        int tot;
        if (!set) return '0;
        idx = dec ? 16 - r : r + 1;
        tot = 0;
        for (int k = 1; k <= idx; k++) tot += sh[k];
        return rotl(base, tot % 28);
    endfunction

    always @(posedge Clk) begin
        for (int i = 0; i < 2; i++) begin
            if (Rst) begin
                m_phase[i]  <= 0;
                m_round[i]  <= 0;
                m_dec[i]    <= 1'b0;
                m_keyset[i] <= 1'b0;
            end else if (m_phase[i] == 0) begin
                if (Start) begin
                    m_phase[i]  <= 1;
                    m_round[i]  <= 0;
                    m_dec[i]    <= Decrypt;
                    m_c0[i]     <= Key_In[56:29];
                    m_d0[i]     <= Key_In[28:1];
                    m_keyset[i] <= 1'b1;
                end
            end else if (m_phase[i] == 1) begin
                if (!(Stall && se[i])) begin
                    if (m_round[i] == 15) m_phase[i] <= 2;
                    else m_round[i] <= m_round[i] + 1;
                end
            end else begin
                if (Out_Ready) m_phase[i] <= 0;
            end
        end
    end

    always @(negedge Clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("load_data[%0d]", i), 32'(ld[i]),
                    32'(!Rst && m_phase[i] == 0 && Start));
                chk($sformatf("round_en[%0d]", i), 32'(re[i]),
                    32'(!Rst && m_phase[i] == 1 && !(Stall && se[i])));
                chk($sformatf("round_num[%0d]", i), 32'(rn[i]), 32'(m_round[i]));
                chk($sformatf("last_round[%0d]", i), 32'(lr[i]),
                    32'(m_phase[i] == 1 && m_round[i] == 15));
                chk($sformatf("busy[%0d]", i), 32'(busy[i]), 32'(m_phase[i] != 0));
                chk($sformatf("out_valid[%0d]", i), 32'(ov[i]), 32'(m_phase[i] == 2));
                chk($sformatf("key_c[%0d]", i), 32'(kc[i]),
                    32'(exp_key(m_c0[i], m_dec[i], m_round[i], m_keyset[i])));
                chk($sformatf("key_d[%0d]", i), 32'(kd[i]),
                    32'(exp_key(m_d0[i], m_dec[i], m_round[i], m_keyset[i])));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Inputs are scrambled after the accepting edge; the block must ignore them.
    task automatic start_blk(input bit dec, input logic [27:0] c, input logic [27:0] d);
        Key_In  = {c, d};
        Decrypt = dec;
        Start   = 1'b1;
        tick();
        Start   = 1'b0;
        Decrypt = ~dec;
        Key_In  = ~{c, d};
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        Out_Ready = 1'b1;
        while (busy !== 2'b00 && k < 100) begin
            tick();
            k++;
        end
        chk("wait_idle", 32'(busy), 32'h0);
    endtask

    int          n;
    int          cnt;
    logic [27:0] kc_hold;
    logic [27:0] kd_hold;

    initial begin
        tick();
        tick();
        chk_en = 1'b1;
        chk("rst_busy", 32'(busy[0]), 32'h0);
        chk("rst_round", 32'(rn[0]), 32'h0);
        chk("rst_key_c", 32'(kc[0]), 32'h0);
        chk("rst_valid", 32'(ov[0]), 32'h0);
        Rst = 1'b0;
        tick();

        // Encrypt key walk
        start_blk(1'b0, 28'h0000001, 28'h0000001);
        n = 0;
        chk("enc_r0_c", 32'(kc[0]), 32'h0000002);
        chk("enc_r0_d", 32'(kd[0]), 32'h0000002);
        tick(); n++;
        chk("enc_r1_c", 32'(kc[0]), 32'h0000004);
        tick(); n++;
        chk("enc_r2_c", 32'(kc[0]), 32'h0000010);
        while (ov[0] !== 1'b1 && n < 40) begin
            if (n == 15) begin
                chk("enc_r15_c", 32'(kc[0]), 32'h0000001);
                chk("enc_r15_last", 32'(lr[0]), 32'h1);
            end
            tick(); n++;
        end
        chk("enc_latency", 32'(n), 32'd16);
        wait_idle();

        // Decrypt key walk
        start_blk(1'b1, 28'h0000001, 28'h0000001);
        n = 0;
        chk("dec_r0_c", 32'(kc[0]), 32'h0000001);
        tick(); n++;
        chk("dec_r1_c", 32'(kc[0]), 32'h8000000);
        tick(); n++;
        chk("dec_r2_c", 32'(kc[0]), 32'h2000000);
        while (ov[0] !== 1'b1 && n < 40) begin
            if (n == 15) chk("dec_r15_c", 32'(kc[0]), 32'h0000002);
            tick(); n++;
        end
        chk("dec_latency", 32'(n), 32'd16);
        wait_idle();

        // Stall three cycles in round 5
        start_blk(1'b0, 28'h0000001, 28'h0000001);
        n = 0;
        repeat (5) begin tick(); n++; end
        chk("stall_r5", 32'(rn[0]), 32'd5);
        Stall = 1'b1;
        #1;
        chk("stall_round_en", 32'(re[0]), 32'h0);
        kc_hold = kc[0];
        kd_hold = kd[0];
        repeat (3) begin
            tick(); n++;
            chk("stall_hold_round", 32'(rn[0]), 32'd5);
            chk("stall_hold_c", 32'(kc[0]), 32'(kc_hold));
            chk("stall_hold_d", 32'(kd[0]), 32'(kd_hold));
        end
        Stall = 1'b0;
        while (ov[0] !== 1'b1 && n < 40) begin tick(); n++; end
        chk("stall_latency", 32'(n), 32'd19);
        wait_idle();

        // Output backpressure; Start during OUT and on the return edge ignored
        Out_Ready = 1'b0;
        start_blk(1'b0, 28'h0000001, 28'h0000001);
        n = 0;
        while (ov[0] !== 1'b1 && n < 40) begin tick(); n++; end
        chk("bp_latency", 32'(n), 32'd16);
        for (int k = 0; k < 4; k++) begin
            Start = (k == 1);
            tick();
            chk("bp_valid_held", 32'(ov[0]), 32'h1);
            chk("bp_busy_held", 32'(busy[0]), 32'h1);
            chk("bp_round_held", 32'(rn[0]), 32'd15);
        end
        Out_Ready = 1'b1;
        Start     = 1'b1;
        tick();
        chk("bp_return_busy", 32'(busy[0]), 32'h0);
        chk("bp_return_valid", 32'(ov[0]), 32'h0);
        chk("bp_accept_load", 32'(ld[0]), 32'h1);
        tick();
        Start = 1'b0;
        chk("bp_accept_busy", 32'(busy[0]), 32'h1);
        chk("bp_accept_round", 32'(rn[0]), 32'd0);
        wait_idle();

        // Mid-run reset at round 9
        start_blk(1'b0, 28'h0000001, 28'h0000001);
        repeat (9) tick();
        chk("mr_round9", 32'(rn[0]), 32'd9);
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        chk("mr_busy", 32'(busy[0]), 32'h0);
        chk("mr_round", 32'(rn[0]), 32'h0);
        chk("mr_key_c", 32'(kc[0]), 32'h0);
        chk("mr_key_d", 32'(kd[0]), 32'h0);
        cnt = 0;
        repeat (20) begin
            tick();
            if (ov[0] === 1'b1) cnt++;
        end
        chk("mr_no_valid", 32'(cnt), 32'h0);
        start_blk(1'b0, 28'h0000001, 28'h0000001);
        n = 0;
        while (ov[0] !== 1'b1 && n < 40) begin tick(); n++; end
        chk("mr_restart_latency", 32'(n), 32'd16);
        wait_idle();

        // STALL_EN=0 instance with Stall held high
        Stall = 1'b1;
        start_blk(1'b0, 28'h0000001, 28'h0000001);
        n   = 0;
        cnt = 0;
        while (ov[1] !== 1'b1 && n < 40) begin
            if (re[1] === 1'b1) cnt++;
            tick(); n++;
        end
        chk("ns_round_en_pulses", 32'(cnt), 32'd16);
        chk("ns_latency", 32'(n), 32'd16);
        chk("ns_stalled_twin_round", 32'(rn[0]), 32'd0);
        chk("ns_stalled_twin_busy", 32'(busy[0]), 32'h1);
        Stall = 1'b0;
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
